hazard_control_unit: RTL and testbench

- Central pipeline sequencer for the 5-stage RISC-V core. Works alongside the forwarding logic and covers the hazards that forwarding cannot resolve.
- Load-use hazards: inserts a bubble.
- Taken branches in EX: flushes the younger instructions.
- Multi-cycle mul/div (MDU) in EX: freezes the front of the pipeline and drains the back until the MDU is done or times out.
- Drives the write-enable, flush and bubble controls for the PC, IF/ID, ID/EX and EX/MEM registers, and keeps hazard performance counters.

---
 rtl/hazard_control_unit.sv | 131 +++++++++++++
 tb/tb_hazard_control_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Pipeline hazard sequencer: load-use bubbles, branch flushes and multi-cycle MDU freeze/drain
// with a timeout abort. It also keeps the stall and flush performance counters.
module hazard_control_unit #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_use_rs1,
  input  logic             if_id_use_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_MemRead,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_valid,
  input  logic             mdu_done,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             mdu_start,
  output logic             mdu_abort,
  output logic             mdu_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             dbg_state
);

  localparam int TW = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MDU_TIMEOUT - 1);

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [TW-1:0]    r_tmo_cnt;
  logic [TW-1:0]    w_tmo_next;
  logic             r_mdu_error;
  logic             w_set_error;
  logic             w_flush_inc;
  logic             w_load_use;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  assign w_load_use = id_ex_MemRead && (id_ex_rd != 5'd0) &&
                      (((id_ex_rd == if_id_rs1) && if_id_use_rs1) ||
                       ((id_ex_rd == if_id_rs2) && if_id_use_rs2));

  // Priority in RUN: branch squashes everything, then MDU launch, then load-use.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    mdu_start     = 1'b0;
    mdu_abort     = 1'b0;
    w_state_next  = r_state;
    w_tmo_next    = r_tmo_cnt;
    w_set_error   = 1'b0;
    w_flush_inc   = 1'b0;
    case (r_state)
      RUN: begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          w_flush_inc = 1'b1;
        end else if (ex_mdu_valid) begin
          mdu_start     = 1'b1;
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          w_state_next  = MDU_WAIT;
          w_tmo_next    = '0;
        end else if (w_load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      MDU_WAIT: begin
        if (mdu_done) begin
          w_state_next = RUN;
        end else if (r_tmo_cnt == TMO_LAST) begin
          // Abort: let the MDU instruction retire as a NOP and resume.
          mdu_abort     = 1'b1;
          ex_mem_bubble = 1'b1;
          w_set_error   = 1'b1;
          w_state_next  = RUN;
        end else begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          w_tmo_next    = r_tmo_cnt + TW'(1);
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_tmo_cnt      <= '0;
      r_mdu_error    <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_tmo_cnt <= w_tmo_next;
      if (w_set_error) r_mdu_error <= 1'b1;
      if (!pc_write)   r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_flush_inc) r_flush_count  <= r_flush_count + CNT_W'(1);
    end
  end

  assign mdu_error    = r_mdu_error;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: load-use, branch, MDU done/timeout and async reset.
module tb_hazard_control_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  if_id_rs1, if_id_rs2, id_ex_rd;
  logic        if_id_use_rs1, if_id_use_rs2, id_ex_MemRead;
  logic        ex_branch_taken, ex_mdu_valid, mdu_done;
  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic        ex_mem_bubble, mdu_start, mdu_abort, mdu_error, dbg_state;
  logic [31:0] stall_cycles, flush_count;

  int n_checks;
  int n_fails;

  // Control vector order: pc_w, ifid_w, ifid_f, idex_w, idex_f, bubble, start, abort
  localparam logic [7:0] C_DEF    = 8'b1101_0000;
  localparam logic [7:0] C_LOADU  = 8'b0001_1000;
  localparam logic [7:0] C_BRANCH = 8'b1111_1000;
  localparam logic [7:0] C_LAUNCH = 8'b0000_0110;
  localparam logic [7:0] C_WAIT   = 8'b0000_0100;
  localparam logic [7:0] C_ABORT  = 8'b1101_0101;

  hazard_control_unit #(.MDU_TIMEOUT(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_MemRead(id_ex_MemRead),
    .ex_branch_taken(ex_branch_taken), .ex_mdu_valid(ex_mdu_valid), .mdu_done(mdu_done),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
    .mdu_start(mdu_start), .mdu_abort(mdu_abort), .mdu_error(mdu_error),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctrl();
    return {24'd0, pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
            ex_mem_bubble, mdu_start, mdu_abort};
  endfunction

  task automatic idle_inputs();
    if_id_rs1 = 5'd0; if_id_rs2 = 5'd0; id_ex_rd = 5'd0;
    if_id_use_rs1 = 1'b0; if_id_use_rs2 = 1'b0; id_ex_MemRead = 1'b0;
    ex_branch_taken = 1'b0; ex_mdu_valid = 1'b0; mdu_done = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2);
    id_ex_MemRead = 1'b1; id_ex_rd = rd;
    if_id_rs1 = rs1; if_id_use_rs1 = u1;
    if_id_rs2 = rs2; if_id_use_rs2 = u2;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_ctrl", ctrl(), {24'd0, C_DEF});
    check_val("reset_stall", stall_cycles, 32'd0);
    check_val("reset_flush", flush_count, 32'd0);
    check_val("reset_error", {31'd0, mdu_error}, 32'd0);
    check_val("reset_state", {31'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_val("idle_ctrl", ctrl(), {24'd0, C_DEF});

    // Load-use on rs2
    set_load_use(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
    settle();
    check_val("lu_rs2_ctrl", ctrl(), {24'd0, C_LOADU});
    tick();
    idle_inputs();
    settle();
    check_val("lu_stall_1", stall_cycles, 32'd1);
    check_val("lu_after_ctrl", ctrl(), {24'd0, C_DEF});
    check_val("lu_state_run", {31'd0, dbg_state}, 32'd0);

    // Load to x0 and unused-source cases: no stall
    set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    settle();
    check_val("lu_x0_ctrl", ctrl(), {24'd0, C_DEF});
    tick();
    set_load_use(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
    settle();
    check_val("lu_unused_ctrl", ctrl(), {24'd0, C_DEF});
    tick();
    check_val("lu_nostall_cnt", stall_cycles, 32'd1);

    // Load-use on rs1
    set_load_use(5'd9, 5'd9, 1'b1, 5'd2, 1'b0);
    settle();
    check_val("lu_rs1_ctrl", ctrl(), {24'd0, C_LOADU});
    tick();
    idle_inputs();
    settle();
    check_val("lu_stall_2", stall_cycles, 32'd2);

    // Branch overrides load-use
    set_load_use(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
    ex_branch_taken = 1'b1;
    settle();
    check_val("br_lu_ctrl", ctrl(), {24'd0, C_BRANCH});
    tick();
    idle_inputs();
    settle();
    check_val("br_flush_1", flush_count, 32'd1);
    check_val("br_stall_same", stall_cycles, 32'd2);

    // Branch wins over simultaneous MDU request
    ex_branch_taken = 1'b1;
    ex_mdu_valid = 1'b1;
    settle();
    check_val("br_mdu_ctrl", ctrl(), {24'd0, C_BRANCH});
    tick();
    idle_inputs();
    settle();
    check_val("br_flush_2", flush_count, 32'd2);
    check_val("br_mdu_state", {31'd0, dbg_state}, 32'd0);

    // mdu_done in RUN is ignored
    mdu_done = 1'b1;
    settle();
    check_val("done_run_ctrl", ctrl(), {24'd0, C_DEF});
    tick();
    idle_inputs();
    settle();
    check_val("done_run_state", {31'd0, dbg_state}, 32'd0);

    // MDU normal: launch with a load-use present (suppressed), done on cycle 4
    ex_mdu_valid = 1'b1;
    set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    settle();
    check_val("mdu_launch_ctrl", ctrl(), {24'd0, C_LAUNCH});
    tick();
    idle_inputs();
    for (int c = 1; c <= 3; c++) begin
      settle();
      check_val($sformatf("mdu_wait_%0d_ctrl", c), ctrl(), {24'd0, C_WAIT});
      check_val($sformatf("mdu_wait_%0d_state", c), {31'd0, dbg_state}, 32'd1);
      tick();
    end
    mdu_done = 1'b1;
    ex_branch_taken = 1'b1;
    settle();
    check_val("mdu_done_ctrl", ctrl(), {24'd0, C_DEF});
    tick();
    idle_inputs();
    settle();
    check_val("mdu_done_state", {31'd0, dbg_state}, 32'd0);
    check_val("mdu_done_stall", stall_cycles, 32'd6);
    check_val("mdu_done_flush", flush_count, 32'd2);

    // Done coinciding with the timeout cycle: treated as done
    ex_mdu_valid = 1'b1;
    settle();
    check_val("edge_launch_ctrl", ctrl(), {24'd0, C_LAUNCH});
    tick();
    idle_inputs();
    for (int c = 1; c <= 7; c++) begin
      settle();
      check_val($sformatf("edge_wait_%0d_ctrl", c), ctrl(), {24'd0, C_WAIT});
      tick();
    end
    mdu_done = 1'b1;
    settle();
    check_val("edge_done_ctrl", ctrl(), {24'd0, C_DEF});
    tick();
    idle_inputs();
    settle();
    check_val("edge_error", {31'd0, mdu_error}, 32'd0);
    check_val("edge_state", {31'd0, dbg_state}, 32'd0);
    check_val("edge_stall", stall_cycles, 32'd14);

    // Timeout: abort on cycle 8 after launch
    ex_mdu_valid = 1'b1;
    settle();
    check_val("tmo_launch_ctrl", ctrl(), {24'd0, C_LAUNCH});
    tick();
    idle_inputs();
    for (int c = 1; c <= 7; c++) begin
      settle();
      check_val($sformatf("tmo_wait_%0d_ctrl", c), ctrl(), {24'd0, C_WAIT});
      tick();
    end
    settle();
    check_val("tmo_abort_ctrl", ctrl(), {24'd0, C_ABORT});
    tick();
    check_val("tmo_error", {31'd0, mdu_error}, 32'd1);
    check_val("tmo_state", {31'd0, dbg_state}, 32'd0);
    check_val("tmo_stall", stall_cycles, 32'd22);
    check_val("tmo_run_ctrl", ctrl(), {24'd0, C_DEF});
    repeat (3) tick();
    check_val("tmo_error_sticky", {31'd0, mdu_error}, 32'd1);

    // Async reset in the middle of MDU_WAIT
    ex_mdu_valid = 1'b1;
    tick();
    idle_inputs();
    tick();
    check_val("ar_pre_state", {31'd0, dbg_state}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("ar_ctrl", ctrl(), {24'd0, C_DEF});
    check_val("ar_state", {31'd0, dbg_state}, 32'd0);
    check_val("ar_stall", stall_cycles, 32'd0);
    check_val("ar_flush", flush_count, 32'd0);
    check_val("ar_error", {31'd0, mdu_error}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_val("ar_release_ctrl", ctrl(), {24'd0, C_DEF});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
